// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types, opcode/ALU-code tables and decode helpers for the control sequencer.
// Contents: state_t, op_class_t, ctl_t (registered datapath strobes), OPC_*/ALU_* constants,
// op_class() and alu_code().
package cpu_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_BINARY,
    CLS_MULDIV,
    CLS_UNARY,
    CLS_HALT,
    CLS_NOP,
    CLS_ILLEGAL
  } op_class_t;

  // Single-bit datapath strobes, registered together.
  typedef struct packed {
    logic pc_out;
    logic pc_in;
    logic inc_pc;
    logic mar_in;
    logic mdr_in;
    logic mdr_out;
    logic read;
    logic ir_in;
    logic y_in;
    logic zlow_in;
    logic zhigh_in;
    logic zlow_out;
    logic zhigh_out;
    logic hi_in;
    logic lo_in;
    logic halted;
    logic illegal;
  } ctl_t;

  localparam logic [4:0] OPC_ADD  = 5'b00011;
  localparam logic [4:0] OPC_SUB  = 5'b00100;
  localparam logic [4:0] OPC_AND  = 5'b00101;
  localparam logic [4:0] OPC_OR   = 5'b00110;
  localparam logic [4:0] OPC_SHR  = 5'b00111;
  localparam logic [4:0] OPC_SHL  = 5'b01000;
  localparam logic [4:0] OPC_ROR  = 5'b01010;
  localparam logic [4:0] OPC_ROL  = 5'b01011;
  localparam logic [4:0] OPC_MUL  = 5'b01110;
  localparam logic [4:0] OPC_DIV  = 5'b01111;
  localparam logic [4:0] OPC_NEG  = 5'b10000;
  localparam logic [4:0] OPC_NOT  = 5'b10001;
  localparam logic [4:0] OPC_NOP  = 5'b11010;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'b00001;
  localparam logic [4:0] ALU_SUB = 5'b00010;
  localparam logic [4:0] ALU_AND = 5'b00011;
  localparam logic [4:0] ALU_OR  = 5'b00100;
  localparam logic [4:0] ALU_SHR = 5'b00101;
  localparam logic [4:0] ALU_SHL = 5'b00110;
  localparam logic [4:0] ALU_ROR = 5'b01011;
  localparam logic [4:0] ALU_ROL = 5'b01100;
  localparam logic [4:0] ALU_MUL = 5'b01101;
  localparam logic [4:0] ALU_DIV = 5'b01110;
  localparam logic [4:0] ALU_NEG = 5'b01111;
  localparam logic [4:0] ALU_NOT = 5'b10000;

  function automatic op_class_t op_class(input logic [4:0] opc);
    case (opc)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
      OPC_SHR, OPC_SHL, OPC_ROR, OPC_ROL: return CLS_BINARY;
      OPC_MUL, OPC_DIV:                   return CLS_MULDIV;
      OPC_NEG, OPC_NOT:                   return CLS_UNARY;
      OPC_HALT:                           return CLS_HALT;
      OPC_NOP:                            return CLS_NOP;
      default:                            return CLS_ILLEGAL;
    endcase
  endfunction

  function automatic logic [4:0] alu_code(input logic [4:0] opc);
    case (opc)
      OPC_ADD: return ALU_ADD;
      OPC_SUB: return ALU_SUB;
      OPC_AND: return ALU_AND;
      OPC_OR:  return ALU_OR;
      OPC_SHR: return ALU_SHR;
      OPC_SHL: return ALU_SHL;
      OPC_ROR: return ALU_ROR;
      OPC_ROL: return ALU_ROL;
      OPC_MUL: return ALU_MUL;
      OPC_DIV: return ALU_DIV;
      OPC_NEG: return ALU_NEG;
      OPC_NOT: return ALU_NOT;
      default: return 5'b00000;
    endcase
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// reg_select_decoder: 4-to-NREGS one-hot decoder with enable; output is all-zero when disabled.
// Ports: en (enable), sel (register index), onehot (decoded strobes).
// Purely combinational; the caller registers the result.
module reg_select_decoder #(
  parameter int NREGS = 16
) (
  input  logic             en,
  input  logic [3:0]       sel,
  output logic [NREGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en && (int'(sel) < NREGS)) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_control_sequencer.sv
// alu_control_sequencer: hardwired Moore control unit for fetch (T0-T2) and ALU execute (T3-T6).
// Ports: Clock, Clear (async active-low), Run, Mem_ready, IR in; Rin_sel/Rout_sel one-hot,
// datapath strobes, OP, Halted, Illegal out. All outputs registered from the next-state decode.
module alu_control_sequencer
  import cpu_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int OPW   = 5
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Run,
  input  logic             Mem_ready,
  input  logic [31:0]      IR,
  output logic [NREGS-1:0] Rin_sel,
  output logic [NREGS-1:0] Rout_sel,
  output logic             PCout,
  output logic             PCin,
  output logic             IncPC,
  output logic             MARin,
  output logic             MDRin,
  output logic             MDRout,
  output logic             Read,
  output logic             IRin,
  output logic             Yin,
  output logic             ZLowin,
  output logic             ZHighin,
  output logic             ZLowout,
  output logic             ZHighout,
  output logic             HIin,
  output logic             LOin,
  output logic [OPW-1:0]   OP,
  output logic             Halted,
  output logic             Illegal
);

  state_t           state, nxt;
  ctl_t             ctl_q, ctl_n;
  logic [OPW-1:0]   op_q, op_n;
  logic [NREGS-1:0] rin_q, rin_n, rout_q, rout_n;
  logic             rin_en, rout_en;
  logic [3:0]       rout_idx;

  logic [4:0] opc;
  logic [3:0] ra, rb, rc;
  op_class_t  cls;
  logic       unused_ir;

  assign opc       = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign cls       = op_class(opc);
  assign unused_ir = ^IR[14:0];

  // Because outputs are registered, Run and Mem_ready are read at the edge that
  // starts the T0/T1 cycle they control. A T0 (T1) cycle that already carried
  // PCout (PCin) is the one that advances; otherwise the state repeats.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: nxt = S_T0;
      S_T0:   nxt = ctl_q.pc_out ? S_T1 : S_T0;
      S_T1:   nxt = ctl_q.pc_in  ? S_T2 : S_T1;
      S_T2:   nxt = S_T3;
      S_T3: begin
        case (cls)
          CLS_BINARY, CLS_MULDIV, CLS_UNARY: nxt = S_T4;
          CLS_HALT:                          nxt = S_HALT;
          default:                           nxt = S_T0;
        endcase
      end
      S_T4:   nxt = (cls == CLS_UNARY)  ? S_T0 : S_T5;
      S_T5:   nxt = (cls == CLS_MULDIV) ? S_T6 : S_T0;
      S_T6:   nxt = S_T0;
      S_HALT: nxt = S_HALT;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ctl_n    = '0;
    op_n     = '0;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rout_idx = rb;
    case (nxt)
      S_T0: begin
        // The first T0 after reset is a plain idle cycle.
        if ((state != S_IDLE) && Run) begin
          ctl_n.pc_out = 1'b1;
          ctl_n.mar_in = 1'b1;
          ctl_n.inc_pc = 1'b1;
        end
      end
      S_T1: begin
        ctl_n.read   = 1'b1;
        ctl_n.mdr_in = 1'b1;
        ctl_n.pc_in  = Mem_ready;
      end
      S_T2: begin
        ctl_n.mdr_out = 1'b1;
        ctl_n.ir_in   = 1'b1;
      end
      S_T3: begin
        case (cls)
          CLS_BINARY, CLS_MULDIV: begin
            rout_en    = 1'b1;
            ctl_n.y_in = 1'b1;
          end
          CLS_UNARY: begin
            rout_en       = 1'b1;
            ctl_n.zlow_in = 1'b1;
          end
          CLS_ILLEGAL: ctl_n.illegal = 1'b1;
          default: ;
        endcase
      end
      S_T4: begin
        if (cls == CLS_UNARY) begin
          ctl_n.zlow_out = 1'b1;
          rin_en         = 1'b1;
        end else begin
          rout_en        = 1'b1;
          rout_idx       = rc;
          ctl_n.zlow_in  = 1'b1;
          ctl_n.zhigh_in = (cls == CLS_MULDIV);
        end
      end
      S_T5: begin
        ctl_n.zlow_out = 1'b1;
        if (cls == CLS_MULDIV) ctl_n.lo_in = 1'b1;
        else                   rin_en      = 1'b1;
      end
      S_T6: begin
        ctl_n.zhigh_out = 1'b1;
        ctl_n.hi_in     = 1'b1;
      end
      S_HALT: ctl_n.halted = 1'b1;
      default: ;
    endcase
    // OP is held steady from operand fetch through writeback.
    if ((nxt inside {S_T3, S_T4, S_T5, S_T6}) &&
        (cls inside {CLS_BINARY, CLS_MULDIV, CLS_UNARY})) begin
      op_n = OPW'(alu_code(opc));
    end
  end

  reg_select_decoder #(.NREGS(NREGS)) u_rin_dec (
    .en     (rin_en),
    .sel    (ra),
    .onehot (rin_n)
  );

  reg_select_decoder #(.NREGS(NREGS)) u_rout_dec (
    .en     (rout_en),
    .sel    (rout_idx),
    .onehot (rout_n)
  );

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state  <= S_IDLE;
      ctl_q  <= '0;
      op_q   <= '0;
      rin_q  <= '0;
      rout_q <= '0;
    end else begin
      state  <= nxt;
      ctl_q  <= ctl_n;
      op_q   <= op_n;
      rin_q  <= rin_n;
      rout_q <= rout_n;
    end
  end

  assign Rin_sel  = rin_q;
  assign Rout_sel = rout_q;
  assign PCout    = ctl_q.pc_out;
  assign PCin     = ctl_q.pc_in;
  assign IncPC    = ctl_q.inc_pc;
  assign MARin    = ctl_q.mar_in;
  assign MDRin    = ctl_q.mdr_in;
  assign MDRout   = ctl_q.mdr_out;
  assign Read     = ctl_q.read;
  assign IRin     = ctl_q.ir_in;
  assign Yin      = ctl_q.y_in;
  assign ZLowin   = ctl_q.zlow_in;
  assign ZHighin  = ctl_q.zhigh_in;
  assign ZLowout  = ctl_q.zlow_out;
  assign ZHighout = ctl_q.zhigh_out;
  assign HIin     = ctl_q.hi_in;
  assign LOin     = ctl_q.lo_in;
  assign OP       = op_q;
  assign Halted   = ctl_q.halted;
  assign Illegal  = ctl_q.illegal;

endmodule

// File: tb/tb_alu_control_sequencer.sv
// tb_alu_control_sequencer: scoreboard bench; per-instruction expected cycle sequences are
// queued by the driver and popped by a monitor every falling edge.
// Inputs change 1 unit after the rising edge; outputs are sampled on the falling edge.
module tb_alu_control_sequencer;
  import cpu_pkg::*;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read, ir_in;
    logic y_in, zlow_in, zhigh_in, zlow_out, zhigh_out, hi_in, lo_in;
    logic [4:0] op;
    logic halted, illegal;
  } obs_t;

  localparam obs_t ZV = '0;
  localparam int CB = 0, CM = 1, CU = 2, CH = 3, CN = 4, CI = 5;

  logic        Clock = 1'b0;
  logic        Clear, Run, Mem_ready;
  logic [31:0] IR;
  logic [15:0] Rin_sel, Rout_sel;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin;
  logic ZLowin, ZHighin, ZLowout, ZHighout, HIin, LOin, Halted, Illegal;
  logic [4:0]  OP;

  obs_t act;
  obs_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;

  alu_control_sequencer #(.NREGS(16), .OPW(5)) dut (
    .Clock(Clock), .Clear(Clear), .Run(Run), .Mem_ready(Mem_ready), .IR(IR),
    .Rin_sel(Rin_sel), .Rout_sel(Rout_sel), .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
    .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .IRin(IRin), .Yin(Yin),
    .ZLowin(ZLowin), .ZHighin(ZHighin), .ZLowout(ZLowout), .ZHighout(ZHighout),
    .HIin(HIin), .LOin(LOin), .OP(OP), .Halted(Halted), .Illegal(Illegal)
  );

  assign act = {Rin_sel, Rout_sel, PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin,
                Yin, ZLowin, ZHighin, ZLowout, ZHighout, HIin, LOin, OP, Halted, Illegal};

  always #5 Clock = ~Clock;

  initial begin
    #400000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Monitor: one expected vector per cycle, plus structural invariants.
  always @(negedge Clock) begin
    if (mon_en) begin
      int nbus;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow t=%0t got=%h want=<nothing queued>", $time, act);
      end else begin
        obs_t e;
        e = exp_q.pop_front();
        if (act !== e) begin
          failures++;
          $display("FAIL cycle_cmp t=%0t got=%h want=%h", $time, act, e);
        end
      end
      nbus = int'(PCout) + int'(MDRout) + int'(ZLowout) + int'(ZHighout) + $countones(Rout_sel);
      checks++;
      if ($countones(Rin_sel) > 1 || nbus > 1) begin
        failures++;
        $display("FAIL invariant t=%0t rin=%h bus_drivers=%0d want rin<=1hot bus<=1",
                 $time, Rin_sel, nbus);
      end
    end
  end

  task automatic chk(input string name, input obs_t want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  task automatic tick(input obs_t e);
    @(posedge Clock);
    exp_q.push_back(e);
    #1;
  endtask

  // Reference classification straight from the instruction-set table.
  function automatic void ref_decode(input logic [4:0] opc, output int cls, output logic [4:0] alu);
    alu = 5'd0;
    cls = CI;
    case (opc)
      OPC_ADD:  begin cls = CB; alu = 5'b00001; end
      OPC_SUB:  begin cls = CB; alu = 5'b00010; end
      OPC_AND:  begin cls = CB; alu = 5'b00011; end
      OPC_OR:   begin cls = CB; alu = 5'b00100; end
      OPC_SHR:  begin cls = CB; alu = 5'b00101; end
      OPC_SHL:  begin cls = CB; alu = 5'b00110; end
      OPC_ROR:  begin cls = CB; alu = 5'b01011; end
      OPC_ROL:  begin cls = CB; alu = 5'b01100; end
      OPC_MUL:  begin cls = CM; alu = 5'b01101; end
      OPC_DIV:  begin cls = CM; alu = 5'b01110; end
      OPC_NEG:  begin cls = CU; alu = 5'b01111; end
      OPC_NOT:  begin cls = CU; alu = 5'b10000; end
      OPC_HALT: cls = CH;
      OPC_NOP:  cls = CN;
      default:  cls = CI;
    endcase
  endfunction

  // Drives one full instruction: idle T0 cycles, fetch, n_wait memory wait
  // states, then execution. exec_limit truncates the execute phase.
  task automatic run_instr(input logic [31:0] ir, input int n_idle, input int n_wait,
                           input int exec_limit);
    obs_t e;
    obs_t ex[$];
    int cls;
    logic [4:0] alu;
    logic [3:0] ra, rb, rc;
    ref_decode(ir[31:27], cls, alu);
    ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];

    for (int i = 0; i < n_idle; i++) begin
      Run = 1'b0; Mem_ready = 1'($urandom_range(0, 1));
      tick(ZV);
    end
    Run = 1'b1; Mem_ready = 1'($urandom_range(0, 1));
    e = ZV; e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1;
    tick(e);
    for (int i = 0; i < n_wait; i++) begin
      Run = 1'($urandom_range(0, 1)); Mem_ready = 1'b0; IR = $urandom;
      e = ZV; e.read = 1; e.mdr_in = 1;
      tick(e);
    end
    Run = 1'($urandom_range(0, 1)); Mem_ready = 1'b1; IR = $urandom;
    e = ZV; e.read = 1; e.mdr_in = 1; e.pc_in = 1;
    tick(e);
    Run = 1'($urandom_range(0, 1)); Mem_ready = 1'($urandom_range(0, 1)); IR = $urandom;
    e = ZV; e.mdr_out = 1; e.ir_in = 1;
    tick(e);
    IR = ir;

    if (cls == CB || cls == CM) begin
      e = ZV; e.rout[rb] = 1'b1; e.y_in = 1; e.op = alu; ex.push_back(e);
      e = ZV; e.rout[rc] = 1'b1; e.zlow_in = 1; e.zhigh_in = (cls == CM); e.op = alu;
      ex.push_back(e);
      e = ZV; e.zlow_out = 1; e.op = alu;
      if (cls == CB) e.rin[ra] = 1'b1; else e.lo_in = 1;
      ex.push_back(e);
      if (cls == CM) begin
        e = ZV; e.zhigh_out = 1; e.hi_in = 1; e.op = alu; ex.push_back(e);
      end
    end else if (cls == CU) begin
      e = ZV; e.rout[rb] = 1'b1; e.zlow_in = 1; e.op = alu; ex.push_back(e);
      e = ZV; e.zlow_out = 1; e.rin[ra] = 1'b1; e.op = alu; ex.push_back(e);
    end else if (cls == CI) begin
      e = ZV; e.illegal = 1; ex.push_back(e);
    end else begin
      ex.push_back(ZV);
    end

    for (int i = 0; i < ex.size() && i < exec_limit; i++) begin
      Run = 1'($urandom_range(0, 1)); Mem_ready = 1'($urandom_range(0, 1));
      tick(ex[i]);
    end
  endtask

  initial begin
    obs_t hv;
    Clear = 1'b0; Run = 1'b0; Mem_ready = 1'b0; IR = '0;
    hv = ZV; hv.halted = 1'b1;

    #2 chk("reset_outputs", ZV);
    @(posedge Clock); #1;
    chk("reset_held", ZV);
    Clear = 1'b1;
    tick(ZV);          // IDLE -> T0
    mon_en = 1'b1;
    tick(ZV);          // T0 holds with Run = 0
    tick(ZV);

    run_instr(32'h53320000, 0, 0, 99);                      // ROR R6,R6,R4
    run_instr({OPC_ADD, 4'd9, 4'd10, 4'd11, 15'h1234}, 1, 3, 99);
    run_instr({OPC_MUL, 4'd7, 4'd2, 4'd3, 15'h0}, 0, 0, 99);
    run_instr({OPC_NOT, 4'd1, 4'd5, 4'd0, 15'h0}, 0, 1, 99);
    run_instr({OPC_ADD, 4'd0, 4'd0, 4'd0, 15'h0}, 2, 0, 99);  // Ra = Rb = Rc = R0
    run_instr({OPC_DIV, 4'd15, 4'd15, 4'd15, 15'h7fff}, 0, 2, 99);
    run_instr({5'b11111, 27'h5a5a5a5}, 0, 0, 99);           // undecodable opcode
    run_instr({OPC_NOP, 27'h0}, 1, 0, 99);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] r;
      r = $urandom;
      while (r[31:27] == OPC_HALT) r = $urandom;
      run_instr(r, $urandom_range(0, 2), $urandom_range(0, 3), 99);
    end

    // Asynchronous clear in the middle of T4 of a binary instruction.
    run_instr({OPC_SUB, 4'd3, 4'd4, 4'd5, 15'h0}, 0, 0, 2);
    @(negedge Clock); #1;
    mon_en = 1'b0;
    Clear = 1'b0;
    #1 chk("async_clear_mid_t4", ZV);
    @(posedge Clock); #1;
    chk("clear_held_idle", ZV);
    Clear = 1'b1; Run = 1'b0;
    tick(ZV);          // IDLE -> T0
    mon_en = 1'b1;
    run_instr({OPC_OR, 4'd2, 4'd8, 4'd12, 15'h0}, 0, 0, 99);

    // HALT: stays halted whatever Run does, until Clear.
    run_instr({OPC_HALT, 27'h0}, 0, 1, 99);
    for (int i = 0; i < 5; i++) begin
      Run = 1'($urandom_range(0, 1)); Mem_ready = 1'($urandom_range(0, 1));
      tick(hv);
    end
    @(negedge Clock); #1;
    mon_en = 1'b0;
    Clear = 1'b0;
    #1 chk("halt_cleared", ZV);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d want=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_control_sequencer.md
Name: alu_control_sequencer

Overview:
- Hardwired Moore control unit that drives the existing datapath control inputs with the T0..T6 sequences our benches currently drive by hand.
- Covers instruction fetch plus execution of register-register and unary ALU instructions, including HI/LO writeback for mul/div.
- Sits beside datapath: consumes the IR value and a memory-ready flag, emits one-hot register strobes and the rest of the control signals.

Parameters:
- NREGS, 16, number of general registers; sets the width of the one-hot select buses.
- OPW, 5, width of the opcode field and of the ALU OP code.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Clear  in  1  asynchronous, active-low reset.
- Run  in  1  1 = fetch next instruction; sampled only in T0.
- Mem_ready  in  1  memory read complete; sampled only in T1.
- IR  in  32  instruction register contents (datapath IR output).
- Rin_sel  out  NREGS  one-hot register write strobes R0in..R15in.
- Rout_sel  out  NREGS  one-hot register drive strobes R0out..R15out.
- PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, ZLowin, ZHighin, ZLowout, ZHighout, HIin, LOin  out  1 each  datapath strobes.
- OP  out  OPW  ALU operation code.
- Halted  out  1  1 while in the HALT state.
- Illegal  out  1  one-cycle pulse on an undecodable opcode.

Behaviour:
- Clock and reset: one clock domain, Clock. Clear is asynchronous and active-low.
- Reset state: Clear low forces state IDLE, all outputs 0, OP = 0. The reset is asynchronous, including mid-instruction; any partial instruction is abandoned.
- Output timing:
  - All outputs are registered, decoded from the next state.
  - Each strobe is high for exactly the full cycle(s) of its state, with no intra-cycle pulses.
  - OP holds its value from T3 through the writeback state.
- IR fields: opcode = IR[31:27], Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15].
- Opcode classes (cpu_pkg):
  - BINARY: add, sub, and, or, shr, shl, ror, rol.
  - MULDIV: mul, div.
  - UNARY: neg, not.
  - HALT.
  - NOP.
  - Anything else is ILLEGAL.
- States and actions:
  - IDLE: no strobes. Goes to T0 after the first clock with Clear high.
  - T0: if Run = 0, stay in T0 with no strobes. If Run = 1, assert PCout, MARin, IncPC; next state T1.
  - T1: assert Read, MDRin. If Mem_ready = 0, remain in T1 (wait state) with Read/MDRin held. If Mem_ready = 1, additionally assert PCin for that cycle only; next state T2.
  - T2: assert MDRout, IRin; next state T3.
  - T3, opcode decode uses IR:
    - BINARY/MULDIV: Rout_sel[Rb], Yin; next T4.
    - UNARY: Rout_sel[Rb], OP = alu_code(opcode), ZLowin; next T4.
    - NOP: next T0.
    - HALT: next HALT.
    - ILLEGAL: Illegal = 1 for one cycle; next T0.
  - T4:
    - BINARY: Rout_sel[Rc], OP, ZLowin; next T5.
    - MULDIV: Rout_sel[Rc], OP, ZLowin, ZHighin; next T5.
    - UNARY: ZLowout, Rin_sel[Ra]; next T0.
  - T5:
    - BINARY: ZLowout, Rin_sel[Ra]; next T0.
    - MULDIV: ZLowout, LOin; next T6.
  - T6 (MULDIV only): ZHighout, HIin; next T0.
  - HALT: Halted = 1; leaves only via Clear.
- Invariants:
  - Rin_sel and Rout_sel are each one-hot or zero; never more than one bit set.
  - At most one of {PCout, MDRout, ZLowout, ZHighout, any Rout_sel bit} is high in any cycle (single-bus rule).
- Boundary cases:
  - Ra = Rb = Rc is legal.
  - R0 is treated as a normal register.
  - Run is ignored outside T0.
  - Mem_ready is ignored outside T1.
  - IR is sampled combinationally in T3–T6 and must be stable (IRin is low after T2).

Decomposition:
- cpu_pkg holds:
  - state enum.
  - opcode constants OPC_* (e.g. OPC_ROR = 5'b01010).
  - ALU code constants ALU_* (e.g. ALU_ROR = 5'b01011).
  - function alu_code(opcode).
  - function op_class(opcode).
- One sub-module, reg_select_decoder: a 4-to-16 one-hot decoder with enable, instanced twice (Rin, Rout).

Test Plan:
- Reset: Clear = 0 mid-T4 → all outputs 0 same cycle, state IDLE; Clear = 1 → T0 after one clock, then holds with Run = 0.
- ROR: Run = 1, Mem_ready = 1, IR = 32'h53320000 → 6 cycles T0..T5.
  - T3: Rout_sel = 16'h0040, Yin.
  - T4: Rout_sel = 16'h0010, OP = 5'b01011, ZLowin.
  - T5: ZLowout, Rin_sel = 16'h0040.
- Wait states: Mem_ready low for 3 cycles in T1 → Read/MDRin high 4 cycles, PCin high only in the 4th, IRin in the following cycle.
- MUL: IR with OPC_MUL, Rb = 2, Rc = 3 → T4 asserts ZLowin and ZHighin; T5 LOin; T6 HIin; back to T0. Total 7 cycles.
- Unary NOT, Ra = 1, Rb = 5 → T3 Rout_sel = 16'h0020 with ZLowin; T4 Rin_sel = 16'h0002. 5 cycles total.
- Illegal then HALT: unused opcode → Illegal pulse 1 cycle in T3, return to T0; next fetch of OPC_HALT → Halted = 1 and stays there regardless of Run until Clear = 0.
